// File: rtl/tiny_eth_pkg.sv
// tiny_eth shared types and constants.
// Used by the PHY receive front-end and its SFD detector.
package tiny_eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } phy_rx_state_e;

  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

endpackage

// File: rtl/tiny_eth_sfd_detect.sv
// tiny_eth PHY rx: bit history, preamble length counter
// and start-of-frame delimiter comparator.
module tiny_eth_sfd_detect
  import tiny_eth_pkg::*;
#(
  parameter int         MIN_PREAMBLE_BITS = 16,
  parameter logic [7:0] SFD_PATTERN       = SFD_BYTE
) (
  input  logic rx_clk,
  input  logic rst,
  input  logic serial_in,
  input  logic crs_in,
  input  logic enable,
  output logic sfd_hit
);

  localparam int PW = $clog2(MIN_PREAMBLE_BITS + 1);
  localparam logic [PW-1:0] PMAX = PW'(MIN_PREAMBLE_BITS);

  logic [7:0]    hist;
  logic [7:0]    hist_nxt;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_nxt;

  assign hist_nxt = {serial_in, hist[7:1]};
  assign pre_nxt  = (pre_cnt == PMAX) ? PMAX : pre_cnt + 1'b1;

  // pre_cnt saturates, so equality means "long enough"
  assign sfd_hit = enable && crs_in &&
                   (hist_nxt == SFD_PATTERN) &&
                   (pre_nxt == PMAX);

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      pre_cnt <= '0;
    end else begin
      hist    <= crs_in ? hist_nxt : '0;
      pre_cnt <= (crs_in && enable) ? pre_nxt : '0;
    end
  end

endmodule

// File: rtl/tiny_eth_phy_rx.sv
// tiny_eth PHY receive front-end: SFD hunt and deserializer.
// Optional counters: define TINY_ETH_PHY_RX_STATS_EN.
module tiny_eth_phy_rx
  import tiny_eth_pkg::*;
#(
  parameter int         DATA_W            = 4,
  parameter int         MIN_PREAMBLE_BITS = 16,
  parameter int         MAX_FRAME_WORDS   = 3036,
  parameter logic [7:0] SFD_PATTERN       = SFD_BYTE
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              crs_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_dv,
  output logic              rx_er
`ifdef TINY_ETH_PHY_RX_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int BW = $clog2(DATA_W);
  localparam int WW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_FRAME_WORDS);

  phy_rx_state_e   state;
  logic [DATA_W-2:0] sr;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   word_cnt;
  logic            hunting;
  logic            in_data;
  logic            sfd_hit;
  logic            word_done;
  logic            err_evt;

  assign hunting   = (state == IDLE) || (state == PREAMBLE);
  assign in_data   = (state == DATA);
  assign word_done = in_data && crs_in && (bit_cnt == LAST);
  // partial word at carrier loss, or one word past the limit
  assign err_evt   = (in_data && !crs_in && (bit_cnt != '0)) ||
                     (word_done && (word_cnt == WMAX));

  tiny_eth_sfd_detect #(
    .MIN_PREAMBLE_BITS (MIN_PREAMBLE_BITS),
    .SFD_PATTERN       (SFD_PATTERN)
  ) u_sfd (
    .rx_clk    (rx_clk),
    .rst       (rst),
    .serial_in (serial_in),
    .crs_in    (crs_in),
    .enable    (hunting),
    .sfd_hit   (sfd_hit)
  );

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_dv    <= 1'b0;
      rx_er    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_er    <= err_evt;
      unique case (state)
        IDLE: begin
          if (crs_in) state <= PREAMBLE;
        end
        PREAMBLE: begin
          if (!crs_in) begin
            state <= IDLE;
          end else if (sfd_hit) begin
            state    <= DATA;
            bit_cnt  <= '0;
            word_cnt <= '0;
            rx_dv    <= 1'b1;
          end
        end
        DATA: begin
          if (!crs_in) begin
            rx_dv <= 1'b0;
            state <= IDLE;
          end else if (word_done) begin
            bit_cnt <= '0;
            if (word_cnt == WMAX) begin
              rx_dv <= 1'b0;
              state <= DROP;
            end else begin
              rx_data  <= {serial_in, sr};
              rx_valid <= 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end
          end else begin
            sr      <= {serial_in, sr[DATA_W-2:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DROP: begin
          if (!crs_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TINY_ETH_PHY_RX_STATS_EN
  logic clean_end;

  assign clean_end = in_data && !crs_in && (bit_cnt == '0);

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (clean_end && (frame_cnt != 16'hFFFF))
        frame_cnt <= frame_cnt + 1'b1;
      if (err_evt && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tiny_eth_phy_rx.sv
// Bench for tiny_eth_phy_rx: 4-bit and 8-bit instances
// fed the same line, words checked against a queue model.
module tb_tiny_eth_phy_rx;
  import tiny_eth_pkg::*;

  logic       rx_clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       crs_in = 1'b0;

  logic [3:0] rx_data4;
  logic       rx_valid4, rx_dv4, rx_er4;
  logic [7:0] rx_data8;
  logic       rx_valid8, rx_dv8, rx_er8;
`ifdef TINY_ETH_PHY_RX_STATS_EN
  logic [15:0] fc4, ec4, fc8, ec8;
  int st_fr4 = 0, st_er4 = 0, st_fr8 = 0, st_er8 = 0;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] q4[$];
  logic [7:0] q8[$];
  logic [3:0] prev4 = '0;
  logic [7:0] prev8 = '0;
  int obs_er4 = 0, obs_er8 = 0;
  int exp_er4 = 0, exp_er8 = 0;
  logic dv_seen4 = 1'b0, dv_seen8 = 1'b0;

  tiny_eth_phy_rx #(
    .DATA_W(4), .MIN_PREAMBLE_BITS(16), .MAX_FRAME_WORDS(4)
  ) u4 (
    .rx_clk(rx_clk), .rst(rst),
    .serial_in(serial_in), .crs_in(crs_in),
    .rx_data(rx_data4), .rx_valid(rx_valid4),
    .rx_dv(rx_dv4), .rx_er(rx_er4)
`ifdef TINY_ETH_PHY_RX_STATS_EN
    , .frame_cnt(fc4), .err_cnt(ec4)
`endif
  );

  tiny_eth_phy_rx #(
    .DATA_W(8), .MIN_PREAMBLE_BITS(16), .MAX_FRAME_WORDS(4)
  ) u8 (
    .rx_clk(rx_clk), .rst(rst),
    .serial_in(serial_in), .crs_in(crs_in),
    .rx_data(rx_data8), .rx_valid(rx_valid8),
    .rx_dv(rx_dv8), .rx_er(rx_er8)
`ifdef TINY_ETH_PHY_RX_STATS_EN
    , .frame_cnt(fc8), .err_cnt(ec8)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (rx_valid4) begin
      checks++;
      assert (q4.size() > 0) else begin
        errors++;
        $error("FAIL w4_extra: got %0h expected none", rx_data4);
      end
      if (q4.size() > 0) chk("w4_word", int'(rx_data4), int'(q4.pop_front()));
      prev4 = rx_data4;
    end else begin
      chk("w4_hold", int'(rx_data4), int'(prev4));
    end
    if (rx_valid8) begin
      checks++;
      assert (q8.size() > 0) else begin
        errors++;
        $error("FAIL w8_extra: got %0h expected none", rx_data8);
      end
      if (q8.size() > 0) chk("w8_word", int'(rx_data8), int'(q8.pop_front()));
      prev8 = rx_data8;
    end else begin
      chk("w8_hold", int'(rx_data8), int'(prev8));
    end
    chk("w4_val_er", int'(rx_valid4 & rx_er4), 0);
    chk("w8_val_er", int'(rx_valid8 & rx_er8), 0);
    if (rx_er4) obs_er4++;
    if (rx_er8) obs_er8++;
    dv_seen4 = dv_seen4 | rx_dv4;
    dv_seen8 = dv_seen8 | rx_dv8;
  endtask

  // drive at negedge, sample the result at the next negedge
  task automatic tick(input logic s, input logic c);
    serial_in = s;
    crs_in = c;
    @(posedge rx_clk);
    @(negedge rx_clk);
    sample();
  endtask

  task automatic send_byte(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) tick(b[i], 1'b1);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic preamble(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(PREAMBLE_BYTE, 8);
    send_byte(SFD_BYTE, 8);
  endtask

  // reference model: full words up to the limit, error on
  // overflow or a partial trailing word
  task automatic expect_payload(input logic [31:0] pay, input int nbits);
    int f4, f8;
    logic ok4, ok8;
    f4 = nbits / 4;
    f8 = nbits / 8;
    for (int k = 0; k < f4 && k < 4; k++) q4.push_back(pay[4*k +: 4]);
    for (int k = 0; k < f8 && k < 4; k++) q8.push_back(pay[8*k +: 8]);
    ok4 = (f4 <= 4) && (nbits % 4 == 0);
    ok8 = (f8 <= 4) && (nbits % 8 == 0);
    if (!ok4) exp_er4++;
    if (!ok8) exp_er8++;
`ifdef TINY_ETH_PHY_RX_STATS_EN
    if (ok4) st_fr4++; else st_er4++;
    if (ok8) st_fr8++; else st_er8++;
`endif
  endtask

  task automatic end_check(input string tag);
    chk({tag, "_er4"}, obs_er4, exp_er4);
    chk({tag, "_er8"}, obs_er8, exp_er8);
    chk({tag, "_q4"}, q4.size(), 0);
    chk({tag, "_q8"}, q8.size(), 0);
    chk({tag, "_dv4"}, int'(rx_dv4), 0);
    chk({tag, "_dv8"}, int'(rx_dv8), 0);
  endtask

  initial begin
    @(negedge rx_clk);
    gap(3);
    chk("rst_data4", int'(rx_data4), 0);
    chk("rst_data8", int'(rx_data8), 0);
    chk("rst_dv", int'(rx_dv4 | rx_dv8), 0);
    chk("rst_valid", int'(rx_valid4 | rx_valid8), 0);
    chk("rst_er", int'(rx_er4 | rx_er8), 0);
    rst = 1'b1;
    gap(3);

    // nominal frame: 0x12 0xAB
    expect_payload(32'h0000AB12, 16);
    preamble(7);
    chk("nom_dv4_sfd", int'(rx_dv4), 1);
    chk("nom_dv8_sfd", int'(rx_dv8), 1);
    send_byte(8'h12, 8);
    send_byte(8'hAB, 8);
    chk("nom_dv4_last", int'(rx_dv4), 1);
    tick(1'b0, 1'b0);
    chk("nom_dv4_end", int'(rx_dv4), 0);
    chk("nom_data4", int'(rx_data4), 'hA);
    chk("nom_data8", int'(rx_data8), 'hAB);
    gap(2);
    end_check("nom");

    // asynchronous reset in the middle of a frame
    preamble(2);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("mid_dv4", int'(rx_dv4), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data4", int'(rx_data4), 0);
    chk("mid_rst_data8", int'(rx_data8), 0);
    chk("mid_rst_dv", int'(rx_dv4 | rx_dv8), 0);
    chk("mid_rst_vld", int'(rx_valid4 | rx_valid8), 0);
    chk("mid_rst_er", int'(rx_er4 | rx_er8), 0);
    prev4 = '0;
    prev8 = '0;
`ifdef TINY_ETH_PHY_RX_STATS_EN
    chk("mid_rst_fc4", int'(fc4), 0);
    chk("mid_rst_ec8", int'(ec8), 0);
    st_fr4 = 0; st_er4 = 0; st_fr8 = 0; st_er8 = 0;
`endif
    @(negedge rx_clk);
    gap(2);
    rst = 1'b1;
    dv_seen4 = 1'b0;
    dv_seen8 = 1'b0;
    gap(5);
    chk("post_rst_idle", int'(dv_seen4 | dv_seen8), 0);

    // short preamble: first SFD at 12 bits ignored
    expect_payload(32'h0000003C, 8);
    send_byte(8'h05, 4);
    send_byte(SFD_BYTE, 8);
    chk("short_no_dv4", int'(dv_seen4), 0);
    chk("short_no_dv8", int'(dv_seen8), 0);
    send_byte(SFD_BYTE, 8);
    chk("short_dv4", int'(rx_dv4), 1);
    chk("short_dv8", int'(rx_dv8), 1);
    send_byte(8'h3C, 8);
    tick(1'b0, 1'b0);
    gap(2);
    end_check("short");

    // partial word: 6 payload bits
    expect_payload(32'h0000002D, 6);
    preamble(7);
    send_byte(8'h2D, 6);
    tick(1'b0, 1'b0);
    chk("part_er4", int'(rx_er4), 1);
    chk("part_er8", int'(rx_er8), 1);
    chk("part_keep4", int'(rx_data4), 'hD);
    gap(2);
    end_check("part");

    // oversize at 4 bits: 6 words, limit 4
    expect_payload(32'h00654321, 24);
    preamble(7);
    send_byte(8'h21, 8);
    send_byte(8'h43, 8);
    send_byte(8'h65, 8);
    chk("over_dv4", int'(rx_dv4), 0);
    chk("over_dv8", int'(rx_dv8), 1);
    tick(1'b0, 1'b0);
    gap(2);
    end_check("over");

`ifdef TINY_ETH_PHY_RX_STATS_EN
    chk("st_fc4", int'(fc4), st_fr4);
    chk("st_ec4", int'(ec4), st_er4);
    chk("st_fc8", int'(fc8), st_fr8);
    chk("st_ec8", int'(ec8), st_er8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
